// File: rtl/line_fill_buffer.sv
// Instruction-cache line fill buffer: fetches one line critical-word-first in wrap order
// over a single-outstanding memory read port and hands the line to the cache controller.
//
// state | meaning
// IDLE  | no fill in progress; line/address of the last fill are held
// REQ   | read request for word idx presented on the memory port
// WAIT  | request accepted, waiting for its response
// DONE  | full line valid, waiting for the controller to drop LB_Enable
// ABORT | fill cancelled with a response still in flight; swallow it
module line_fill_buffer #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    LB_Enable,
  input  logic [ADDR_W-1:0]       WordAddress,
  output logic                    LB_FirstWord,
  output logic                    LB_Completed,
  output logic [ADDR_W-1:0]       LineAddress,
  output logic [DATA_W-1:0]       CritData,
  output logic [WORDS*DATA_W-1:0] LineData,
  output logic                    Mem_ReqValid,
  input  logic                    Mem_ReqReady,
  output logic [ADDR_W-1:0]       Mem_ReqAddr,
  input  logic                    Mem_RspValid,
  input  logic [DATA_W-1:0]       Mem_RspData
);

  localparam int IW = $clog2(WORDS);
  localparam int IB = IW + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << IB) - 1);
  localparam logic [IW-1:0]     LAST_CNT  = IW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       line_addr_q, line_addr_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]       crit_q, crit_d;
  logic [WORDS*DATA_W-1:0] line_q, line_d;
  logic                    first_q, first_d;
  logic                    comp_q, comp_d;
  logic                    req_valid_q, req_valid_d;

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    crit_d      = crit_q;
    line_d      = line_q;
    first_d     = 1'b0;
    comp_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (LB_Enable) begin
          state_d     = S_REQ;
          line_addr_d = WordAddress & ~LINE_MASK;
          idx_d       = WordAddress[IB-1:2];
          cnt_d       = '0;
        end
      end
      S_REQ: begin
        // A request accepted in the same cycle as the cancel still returns data,
        // so it must be drained rather than dropped.
        if (Mem_ReqReady)    state_d = LB_Enable ? S_WAIT : S_ABORT;
        else if (!LB_Enable) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (!LB_Enable) begin
          state_d = Mem_RspValid ? S_IDLE : S_ABORT;
        end else if (Mem_RspValid) begin
          line_d[idx_q*DATA_W +: DATA_W] = Mem_RspData;
          if (cnt_q == '0) begin
            crit_d  = Mem_RspData;
            first_d = 1'b1;
          end
          idx_d = idx_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            comp_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        if (LB_Enable) comp_d  = 1'b1;
        else           state_d = S_IDLE;
      end
      S_ABORT: begin
        if (Mem_RspValid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      line_addr_q <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      crit_q      <= '0;
      line_q      <= '0;
      first_q     <= 1'b0;
      comp_q      <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      crit_q      <= crit_d;
      line_q      <= line_d;
      first_q     <= first_d;
      comp_q      <= comp_d;
      req_valid_q <= req_valid_d;
    end
  end

  // Completed falls combinationally with LB_Enable so the controller sees it drop at once.
  assign LB_Completed = comp_q & LB_Enable;
  assign LB_FirstWord = first_q;
  assign LineAddress  = line_addr_q;
  assign CritData     = crit_q;
  assign LineData     = line_q;
  assign Mem_ReqValid = req_valid_q;
  assign Mem_ReqAddr  = line_addr_q | ADDR_W'({idx_q, 2'b00});

endmodule

// File: tb/tb_line_fill_buffer.sv
// Bench for line_fill_buffer: memory responder with configurable stall/latency,
// table-driven and random fills checked against an address-arithmetic line model.
module tb_line_fill_buffer;

  localparam int WORDS = 8;

  logic                  Clk = 1'b0;
  logic                  Rst_n;
  logic                  LB_Enable;
  logic [31:0]           WordAddress;
  logic                  LB_FirstWord;
  logic                  LB_Completed;
  logic [31:0]           LineAddress;
  logic [31:0]           CritData;
  logic [WORDS*32-1:0]   LineData;
  logic                  Mem_ReqValid;
  logic                  Mem_ReqReady = 1'b0;
  logic [31:0]           Mem_ReqAddr;
  logic                  Mem_RspValid = 1'b0;
  logic [31:0]           Mem_RspData  = '0;

  line_fill_buffer #(.WORDS(WORDS), .ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .LB_Enable(LB_Enable), .WordAddress(WordAddress),
    .LB_FirstWord(LB_FirstWord), .LB_Completed(LB_Completed), .LineAddress(LineAddress),
    .CritData(CritData), .LineData(LineData), .Mem_ReqValid(Mem_ReqValid),
    .Mem_ReqReady(Mem_ReqReady), .Mem_ReqAddr(Mem_ReqAddr),
    .Mem_RspValid(Mem_RspValid), .Mem_RspData(Mem_RspData)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // memory responder and monitors
  int          cfg_stall = 0;
  int          cfg_dly   = 1;
  logic [31:0] cfg_key   = '0;
  logic [31:0] req_log[$];
  int          first_cnt = 0;
  int          comp_rises = 0;
  bit          both_seen = 0;
  logic [31:0] crit_at_first = '0;

  logic        valid_prev = 0, ready_prev = 0, comp_prev = 0;
  logic [31:0] addr_prev = '0;
  int          wait_cnt = 0, pend_cnt = 0;
  bit          pend = 0;
  logic [31:0] pend_data = '0;

  always @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Mem_ReqReady = 0; Mem_RspValid = 0; Mem_RspData = '0;
      pend = 0; valid_prev = 0; ready_prev = 0; wait_cnt = 0; comp_prev = 0;
    end else begin
      Mem_RspValid = 0;
      if (valid_prev && ready_prev) begin
        req_log.push_back(addr_prev);
        pend = 1; pend_cnt = cfg_dly; pend_data = addr_prev ^ cfg_key; wait_cnt = 0;
      end else if (valid_prev && LB_Enable) begin
        chk("req_hold", {31'd0, Mem_ReqValid, Mem_ReqAddr}, {31'd0, 1'b1, addr_prev});
      end
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          Mem_RspValid = 1; Mem_RspData = pend_data; pend = 0;
        end
      end
      Mem_ReqReady = 0;
      if (Mem_ReqValid) begin
        if (wait_cnt >= cfg_stall) Mem_ReqReady = 1;
        else wait_cnt++;
      end
      valid_prev = Mem_ReqValid; ready_prev = Mem_ReqReady; addr_prev = Mem_ReqAddr;
      if (LB_FirstWord) begin first_cnt++; crit_at_first = CritData; end
      if (LB_Completed && !comp_prev) comp_rises++;
      if (LB_FirstWord && LB_Completed) both_seen = 1;
      comp_prev = LB_Completed;
    end
  end

  task automatic clear_logs();
    req_log.delete();
    first_cnt = 0; comp_rises = 0; both_seen = 0; crit_at_first = '0;
  endtask

  // One full fill; expectations come from line arithmetic, not from DUT internals.
  task automatic run_fill(input logic [31:0] addr, input int stall, input int dly,
                          input logic [31:0] key, input int hold, output int lat);
    logic [31:0] line, crit;
    int idx0;
    cfg_stall = stall; cfg_dly = dly; cfg_key = key;
    clear_logs();
    WordAddress = addr;
    LB_Enable = 1;
    lat = -1;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (c == 1) WordAddress = $urandom;
      if (LB_Completed) begin lat = c; break; end
    end
    chk("fill_done", 64'(lat > 0), 1);

    line = addr & ~32'(WORDS*4 - 1);
    idx0 = int'((addr >> 2) % WORDS);
    crit = (addr & ~32'd3) ^ key;
    chk("latency", 64'(lat), 64'(WORDS*(stall + 1 + dly) + 1));
    chk("line_addr", LineAddress, line);
    chk("crit_data", CritData, crit);
    chk("crit_at_first", crit_at_first, crit);
    chk("first_pulses", 64'(first_cnt), 1);
    chk("req_count", 64'(req_log.size()), WORDS);
    for (int k = 0; k < req_log.size() && k < WORDS; k++)
      chk($sformatf("req_order[%0d]", k), req_log[k], line + 32'(((idx0 + k) % WORDS) * 4));
    for (int i = 0; i < WORDS; i++)
      chk($sformatf("line_word[%0d]", i), LineData[i*32 +: 32], (line + 32'(i*4)) ^ key);

    for (int h = 0; h < hold; h++) begin
      tick();
      chk("comp_hold", LB_Completed, 1);
    end
    LB_Enable = 0;
    #1;
    chk("comp_drop", LB_Completed, 0);
    tick();
    chk("idle_reqvalid", Mem_ReqValid, 0);
    chk("comp_rises", 64'(comp_rises), 1);
    chk("first_and_comp", 64'(both_seen), 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          stall;
    int          dly;
    logic [31:0] key;
    int          hold;
    logic [31:0] exp_line;
    logic [31:0] exp_crit;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit ok;
    vecs[0] = '{32'h0000_1040, 0, 1, 32'h0,         0, 32'h0000_1040, 32'h0000_1040, 17};
    vecs[1] = '{32'h0000_2054, 0, 1, 32'h0,         0, 32'h0000_2040, 32'h0000_2054, 17};
    vecs[2] = '{32'h0000_ABCC, 3, 4, 32'h0,         5, 32'h0000_ABC0, 32'h0000_ABCC, 65};
    vecs[3] = '{32'h0000_3000, 1, 2, 32'hA5A5_0000, 0, 32'h0000_3000, 32'hA5A5_3000, 33};
    vecs[4] = '{32'hFFFF_FFFE, 0, 3, 32'h0,         1, 32'hFFFF_FFE0, 32'hFFFF_FFFC, 33};

    Rst_n = 0; LB_Enable = 0; WordAddress = '0;
    repeat (3) tick();
    chk("rst_first", LB_FirstWord, 0);
    chk("rst_comp", LB_Completed, 0);
    chk("rst_reqvalid", Mem_ReqValid, 0);
    chk("rst_line_addr", LineAddress, 0);
    chk("rst_crit", CritData, 0);
    chk("rst_line_data", 64'(|LineData), 0);
    Rst_n = 1;
    repeat (2) tick();

    foreach (vecs[v]) begin
      run_fill(vecs[v].addr, vecs[v].stall, vecs[v].dly, vecs[v].key, vecs[v].hold, lat);
      chk($sformatf("vec%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_line", v), LineAddress, vecs[v].exp_line);
      chk($sformatf("vec%0d_crit", v), CritData, vecs[v].exp_crit);
    end

    // abort while waiting for the 4th response
    cfg_stall = 0; cfg_dly = 3; cfg_key = '0;
    clear_logs();
    WordAddress = 32'h0000_5010; LB_Enable = 1;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (req_log.size() == 4) begin ok = 1; break; end
    end
    chk("abort_reach", 64'(ok), 1);
    LB_Enable = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("abort_no_req", Mem_ReqValid, 0);
      chk("abort_no_comp", LB_Completed, 0);
    end
    chk("abort_reqs", 64'(req_log.size()), 4);
    chk("abort_comp_rises", 64'(comp_rises), 0);
    chk("abort_first", 64'(first_cnt), 1);
    run_fill(32'h0000_4000, 0, 1, 32'h0, 2, lat);
    chk("post_abort_lat", 64'(lat), 17);

    // asynchronous reset while word 4 is outstanding
    cfg_stall = 0; cfg_dly = 2; cfg_key = '0;
    clear_logs();
    WordAddress = 32'h0000_6008; LB_Enable = 1;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (req_log.size() == 5) begin ok = 1; break; end
    end
    chk("reset_reach", 64'(ok), 1);
    #2;
    Rst_n = 0;
    #1;
    chk("arst_first", LB_FirstWord, 0);
    chk("arst_comp", LB_Completed, 0);
    chk("arst_reqvalid", Mem_ReqValid, 0);
    chk("arst_line_addr", LineAddress, 0);
    chk("arst_crit", CritData, 0);
    chk("arst_line_data", 64'(|LineData), 0);
    LB_Enable = 0;
    tick();
    Rst_n = 1;
    repeat (2) tick();
    chk("post_rst_idle", Mem_ReqValid, 0);

    for (int r = 0; r < 20; r++) begin
      run_fill($urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
               $urandom, int'($urandom_range(0, 3)), lat);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Responder side of the cache line-fill handshake (LB_Enable / LB_FirstWord / LB_Completed / LineAddress) driven by the instruction-cache controller.
- On a miss it fetches one cache line from the memory port, critical word first, in wrap order.
- It flags the critical word as soon as it arrives, then presents the full line for the cache line write.
- Sits between the cache controller/cache array and the AXI-side memory read port.

Parameters:
WORDS, 8, words per cache line (power of two, ≥2); line = WORDS*4 bytes
ADDR_W, 32, byte address width
DATA_W, 32, word width

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
LB_Enable  in  1  fill request/hold from cache controller (level)
WordAddress  in  ADDR_W  missing byte address, sampled at fill start
LB_FirstWord  out  1  one-cycle pulse: critical word valid on CritData
LB_Completed  out  1  whole line valid on LineData; level
LineAddress  out  ADDR_W  line-aligned address of current/last fill
CritData  out  DATA_W  critical word
LineData  out  WORDS*DATA_W  line, word i at bits [i*DATA_W +: DATA_W]
Mem_ReqValid  out  1  read request valid
Mem_ReqReady  in  1  memory accepts request
Mem_ReqAddr  out  ADDR_W  word-aligned request address
Mem_RspValid  in  1  read data valid (always accepted)
Mem_RspData  in  DATA_W  read data

Behaviour:
- Reset (async, Rst_n=0): state IDLE. All outputs 0: LB_FirstWord, LB_Completed, Mem_ReqValid, LineAddress, CritData, LineData. Word counter and index cleared.
- Let IB = log2(WORDS)+2. Index field = WordAddress[IB-1:2].
- States:
  - IDLE → REQ when LB_Enable=1. On that edge: LineAddress <= WordAddress with bits [IB-1:0] zeroed; idx <= index field; cnt <= 0.
  - REQ: Mem_ReqValid=1, Mem_ReqAddr = LineAddress | (idx<<2). On ReqValid&&ReqReady → WAIT.
  - WAIT: on Mem_RspValid, LineData[idx] <= Mem_RspData.
    - If cnt==0: also CritData <= Mem_RspData and LB_FirstWord pulses high the next cycle (registered).
    - idx <= (idx+1) mod WORDS (wrap); cnt <= cnt+1.
    - If cnt==WORDS-1 → DONE, else → REQ.
  - DONE: LB_Completed=1 (registered, first high the cycle after the last response). Held until LB_Enable=0, then → IDLE and LB_Completed drops in that same cycle. LineData and LineAddress are held until the next fill.
- One request outstanding at most. Minimum latency with ReadyReady=1 and 1-cycle response: 2 cycles/word, LB_Completed at cycle 2*WORDS+1 after the start edge.
- Mem_ReqValid, once raised, stays high with a stable Mem_ReqAddr until ReqReady.
- Mem_RspValid outside WAIT: ignored.
- LB_FirstWord and LB_Completed are never high together, except when WORDS... is excluded (WORDS≥2 guarantees this).
- Abort: LB_Enable=0 in REQ → IDLE immediately, ReqValid drops.
  - LB_Enable=0 in WAIT → ABORT state: the outstanding response is awaited and discarded, then → IDLE.
  - No LB_FirstWord/LB_Completed is generated after an abort is detected. LineData contents are undefined after an abort.
- LB_Enable rising in ABORT: not accepted until IDLE.
- Reset mid-fill: immediate IDLE. The memory side is reset by the same Rst_n, so no stale response arrives.
- WordAddress is sampled only at fill start; later changes are ignored.

Test Plan:
- Aligned fill: WordAddress=0x0000_1040, Ready=1, Rsp 1 cycle later with data=addr → requests 0x1040,0x1044..0x105C. LB_FirstWord pulse with CritData=0x1040. LB_Completed at cycle 17. LineAddress=0x1040.
- Critical-word wrap: WordAddress=0x0000_2054 → request order 0x2054,58,5C,40,44,48,4C,50. CritData=0x2054. LineData word5=0x2054, word0=0x2040.
- Backpressure: ReqReady low 3 cycles per request, Rsp delayed 4 cycles → ReqValid/ReqAddr stable while stalled. Exactly 8 requests. Completed once. FirstWord exactly one pulse.
- Completion handshake: hold LB_Enable 5 cycles after Completed → Completed stays high 5 cycles, drops with LB_Enable. Next fill at 0x3000 starts cleanly.
- Abort in WAIT after 3 words, response arrives 2 cycles later → no further requests, no Completed, back to IDLE. A new fill at 0x4000 works.
- Async reset pulse mid-fill (word 4) → all outputs 0 immediately, without waiting for a clock edge. State IDLE.
